async_fifo_wptr_full: RTL and testbench

- Write-domain pointer and full-flag generator for the async FIFO.
- Owns the binary write pointer and drives RAM write enable and address.
- Drives the registered Gray write pointer that the read domain synchronizes.
- Derives full, almost_full, fill level and a sticky overflow flag by comparing its pointer against the read pointer after that pointer has passed through the write-domain two-flop synchronizer.

---
 rtl/async_fifo_wptr_full_if.sv | 44 ++++
 rtl/async_fifo_wptr_full.sv | 71 +++++++
 tb/tb_async_fifo_wptr_full.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/async_fifo_wptr_full_if.sv
// Producer/RAM-side signal bundle for the async FIFO write-pointer block.
// The slave modport is the pointer block; the master modport is the producer side.
interface async_fifo_wptr_full_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic                  wr_en;
    logic                  clr_overflow;
    logic [PW-1:0]         rd_ptr_gray_sync;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [PW-1:0]         wr_ptr_gray;
    logic                  full;
    logic                  almost_full;
    logic [PW-1:0]         wr_level;
    logic                  overflow;

    modport slave (
        input  wr_en,
        input  clr_overflow,
        input  rd_ptr_gray_sync,
        output mem_we,
        output mem_waddr,
        output wr_ptr_gray,
        output full,
        output almost_full,
        output wr_level,
        output overflow
    );

    modport master (
        output wr_en,
        output clr_overflow,
        output rd_ptr_gray_sync,
        input  mem_we,
        input  mem_waddr,
        input  wr_ptr_gray,
        input  full,
        input  almost_full,
        input  wr_level,
        input  overflow
    );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and full/level/overflow generator for the async FIFO.
// Compares the local pointer with the synchronized Gray read pointer using modular arithmetic.
module async_fifo_wptr_full #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALMOST_FULL_TH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    async_fifo_wptr_full_if.slave        bus
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] AfullLevel = PW'(DEPTH - ALMOST_FULL_TH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rbin_sync;
    logic          push;

    always_comb begin
        // Gate with reset so a write held during reset never strobes the RAM.
        push    = bus.wr_en & ~full_q & rst;
        wbin_d  = wbin_q + {{(PW-1){1'b0}}, push};
        wgray_d = (wbin_d >> 1) ^ wbin_d;

        rbin_sync = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_sync[i] = ^(bus.rd_ptr_gray_sync >> i);
        end

        full_d  = (wgray_d == {~bus.rd_ptr_gray_sync[PW-1:PW-2],
                                bus.rd_ptr_gray_sync[PW-3:0]});
        level_d = wbin_d - rbin_sync;
        afull_d = (level_d >= AfullLevel);

        // Set has priority over clear.
        ovf_d = ovf_q;
        if (bus.clr_overflow) ovf_d = 1'b0;
        if (bus.wr_en && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.mem_we      = push;
    assign bus.mem_waddr   = wbin_q[ADDR_WIDTH-1:0];
    assign bus.wr_ptr_gray = wgray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.wr_level    = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full: reset, fill, overflow, drain, wrap, async reset.
module tb_async_fifo_wptr_full;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    async_fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

    async_fifo_wptr_full #(
        .ADDR_WIDTH    (AW),
        .ALMOST_FULL_TH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_gray"},  32'(bus.wr_ptr_gray), 0);
        check({tag, "_full"},  32'(bus.full), 0);
        check({tag, "_afull"}, 32'(bus.almost_full), 0);
        check({tag, "_level"}, 32'(bus.wr_level), 0);
        check({tag, "_ovf"},   32'(bus.overflow), 0);
        check({tag, "_we"},    32'(bus.mem_we), 0);
    endtask

    initial begin
        logic [PW-1:0] wb;
        logic [PW-1:0] prev_gray;

        bus.wr_en            = 1'b0;
        bus.clr_overflow     = 1'b0;
        bus.rd_ptr_gray_sync = '0;

        // 1. Reset held while wr_en toggles
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.wr_en = ~bus.wr_en;
            #1;
            check_all_clear("rst_hold");
        end
        bus.wr_en = 1'b1;
        rst       = 1'b1;
        #1;
        check("first_we",    32'(bus.mem_we), 1);
        check("first_waddr", 32'(bus.mem_waddr), 0);

        // 2. Fill 16 entries with read pointer at 0
        for (int i = 0; i < 16; i++) begin
            check("fill_waddr", 32'(bus.mem_waddr), 32'(i));
            check("fill_we",    32'(bus.mem_we), 1);
            tick();
            check("fill_level", 32'(bus.wr_level), 32'(i + 1));
            check("fill_afull", 32'(bus.almost_full), 32'(i + 1 >= 14));
            check("fill_full",  32'(bus.full), 32'(i + 1 == 16));
        end
        check("full_gray", 32'(bus.wr_ptr_gray), 32'(5'b11000));

        // 3. Writes while full
        check("full_we_blocked", 32'(bus.mem_we), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_set",   32'(bus.overflow), 1);
            check("ovf_gray",  32'(bus.wr_ptr_gray), 32'(5'b11000));
            check("ovf_we",    32'(bus.mem_we), 0);
        end
        bus.wr_en        = 1'b0;
        bus.clr_overflow = 1'b1;
        tick();
        check("ovf_clear", 32'(bus.overflow), 0);
        bus.wr_en = 1'b1;
        tick();
        check("ovf_set_wins", 32'(bus.overflow), 1);
        bus.wr_en        = 1'b0;
        bus.clr_overflow = 1'b0;

        // 4. Drain becomes visible via synchronized read pointer (binary 3)
        bus.rd_ptr_gray_sync = 5'b00010;
        tick();
        check("drain_full",  32'(bus.full), 0);
        check("drain_level", 32'(bus.wr_level), 13);
        check("drain_afull", 32'(bus.almost_full), 0);
        bus.wr_en = 1'b1;
        #1;
        check("drain_we",    32'(bus.mem_we), 1);
        check("drain_waddr", 32'(bus.mem_waddr), 0);
        tick();
        check("drain_level2", 32'(bus.wr_level), 14);
        check("drain_afull2", 32'(bus.almost_full), 1);
        bus.wr_en = 1'b0;

        // 5. 40 writes with read pointer trailing by 4; pointer wraps 31 -> 0
        wb        = 5'd17;
        prev_gray = bus.wr_ptr_gray;
        check("wrap_start_gray", 32'(prev_gray), 32'(b2g(wb)));
        for (int i = 0; i < 40; i++) begin
            bus.rd_ptr_gray_sync = b2g(wb - 5'd4);
            bus.wr_en            = 1'b1;
            #1;
            check("wrap_waddr", 32'(bus.mem_waddr), 32'(wb[AW-1:0]));
            tick();
            wb = wb + 5'd1;
            check("wrap_gray",    32'(bus.wr_ptr_gray), 32'(b2g(wb)));
            check("wrap_hamming", 32'($countones(bus.wr_ptr_gray ^ prev_gray) <= 1), 1);
            check("wrap_level",   32'(bus.wr_level), 5);
            check("wrap_full",    32'(bus.full), 0);
            check("wrap_afull",   32'(bus.almost_full), 0);
            prev_gray = bus.wr_ptr_gray;
        end
        bus.wr_en = 1'b0;

        // 6. Async reset in the middle of a fill
        bus.rd_ptr_gray_sync = b2g(wb);
        bus.wr_en            = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_level", 32'(bus.wr_level), 7);
        #2;
        rst                  = 1'b0;
        bus.rd_ptr_gray_sync = '0;
        #1;
        check_all_clear("async_rst");
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_we",    32'(bus.mem_we), 1);
        check("post_rst_waddr", 32'(bus.mem_waddr), 0);
        tick();
        check("post_rst_level", 32'(bus.wr_level), 1);
        check("post_rst_gray",  32'(bus.wr_ptr_gray), 1);
        bus.wr_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
